// File: rtl/sv_qual_seq_mon.sv
// Multi-channel trig->resp sequence monitor with one-hot-0 check,
// cover-hit counter and saturating failure counter.
module sv_qual_seq_mon #(
   parameter int NUM_CH = 4,
   parameter int DLY    = 10,
   parameter int MODE   = 0,
   parameter int SIG_W  = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [NUM_CH-1:0] trig_a,
   input  logic [NUM_CH-1:0] resp_b,
   input  logic [SIG_W-1:0]  sig_in,
   input  logic [SIG_W-1:0]  match_val,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] pass,
   output logic [NUM_CH-1:0] fail,
   output logic              oneh_err,
   output logic [CNT_W-1:0]  cov_cnt,
   output logic [CNT_W-1:0]  fail_cnt
);

   localparam int CW = $clog2(DLY + 1);
   localparam int SW = CNT_W + $clog2(NUM_CH + 1);
   localparam logic [CW-1:0] DLY_C = CW'(DLY);
   localparam logic [SW-1:0] MAX_C = SW'({CNT_W{1'b1}});

   typedef enum logic {IDLE, WAIT} state_t;

   state_t          st_q  [NUM_CH];
   state_t          st_d  [NUM_CH];
   logic [CW-1:0]   cnt_q [NUM_CH];
   logic [CW-1:0]   cnt_d [NUM_CH];
   logic [NUM_CH-1:0] pass_d;
   logic [NUM_CH-1:0] fail_d;
   logic [SW-1:0]   fsum;

   // Per-channel window FSM: next state, window counter and verdict pulses
   always_comb begin
      pass_d = '0;
      fail_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         logic dec;
         st_d[i]  = st_q[i];
         cnt_d[i] = cnt_q[i];
         dec      = 1'b0;
         if (!en) begin
            st_d[i]  = IDLE;
            cnt_d[i] = '0;
         end else if (st_q[i] == IDLE) begin
            if (trig_a[i]) begin
               st_d[i]  = WAIT;
               cnt_d[i] = CW'(1);
            end
         end else begin
            dec = (cnt_q[i] == DLY_C) ||
                  ((MODE != 0) && resp_b[i]);
            if (dec) begin
               pass_d[i] = resp_b[i];
               fail_d[i] = !resp_b[i];
               // A trigger on the deciding edge opens the next window
               if (trig_a[i]) begin
                  st_d[i]  = WAIT;
                  cnt_d[i] = CW'(1);
               end else begin
                  st_d[i]  = IDLE;
                  cnt_d[i] = '0;
               end
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // Busy flags decoded straight from the state registers
   always_comb begin
      busy = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         busy[i] = (st_q[i] == WAIT);
      end
   end

   // Widened failure sum so the saturation test never sees a wrap
   always_comb begin
      fsum = SW'(fail_cnt) + SW'($countones(fail_d));
   end

   // State, pulse outputs and statistics counters
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            st_q[i]  <= IDLE;
            cnt_q[i] <= '0;
         end
         pass     <= '0;
         fail     <= '0;
         oneh_err <= 1'b0;
         cov_cnt  <= '0;
         fail_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            st_q[i]  <= st_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         pass     <= pass_d;
         fail     <= fail_d;
         oneh_err <= en && ($countones(sig_in) > 1);
         if (en && (sig_in == match_val) && (cov_cnt != '1)) begin
            cov_cnt <= cov_cnt + CNT_W'(1);
         end
         if (fsum > MAX_C) begin
            fail_cnt <= '1;
         end else begin
            fail_cnt <= fsum[CNT_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_sv_qual_seq_mon.sv
// Directed bench for sv_qual_seq_mon: exact mode, window mode
// and a narrow-counter instance for saturation.
module tb_sv_qual_seq_mon;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] trig_a;
   logic [3:0] resp_b;
   logic [3:0] sig_in;
   logic [3:0] match_val;

   logic [3:0]  busy0, pass0, fail0;
   logic        oh0;
   logic [15:0] cov0, fcnt0;
   logic [3:0]  busy1, pass1, fail1;
   logic        oh1;
   logic [15:0] cov1, fcnt1;
   logic [3:0]  busy2, pass2, fail2;
   logic        oh2;
   logic [1:0]  cov2, fcnt2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sv_qual_seq_mon #(.NUM_CH(4), .DLY(10), .MODE(0),
                     .SIG_W(4), .CNT_W(16)) u0 (
      .clk(clk), .rst(rst), .en(en),
      .trig_a(trig_a), .resp_b(resp_b),
      .sig_in(sig_in), .match_val(match_val),
      .busy(busy0), .pass(pass0), .fail(fail0),
      .oneh_err(oh0), .cov_cnt(cov0), .fail_cnt(fcnt0));

   sv_qual_seq_mon #(.NUM_CH(4), .DLY(10), .MODE(1),
                     .SIG_W(4), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .en(en),
      .trig_a(trig_a), .resp_b(resp_b),
      .sig_in(sig_in), .match_val(match_val),
      .busy(busy1), .pass(pass1), .fail(fail1),
      .oneh_err(oh1), .cov_cnt(cov1), .fail_cnt(fcnt1));

   sv_qual_seq_mon #(.NUM_CH(4), .DLY(10), .MODE(0),
                     .SIG_W(4), .CNT_W(2)) u2 (
      .clk(clk), .rst(rst), .en(en),
      .trig_a(trig_a), .resp_b(resp_b),
      .sig_in(sig_in), .match_val(match_val),
      .busy(busy2), .pass(pass2), .fail(fail2),
      .oneh_err(oh2), .cov_cnt(cov2), .fail_cnt(fcnt2));

   typedef struct {
      logic       en;
      logic [3:0] sig;
      logic [3:0] mv;
      logic       exp_oh;
      int         exp_cov;
   } vec_t;

   vec_t tv [11];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      trig_a = '0;
      resp_b = '0;
      en     = 1'b1;
      sig_in = '0;
      match_val = 4'b0010;
      cyc(2);
      rst = 1'b0;
   endtask

   initial begin
      logic [3:0] acc;
      tv[0]  = '{1'b1, 4'b0110, 4'b0010, 1'b1, 0};
      tv[1]  = '{1'b1, 4'b0010, 4'b0010, 1'b0, 1};
      tv[2]  = '{1'b1, 4'b0010, 4'b0010, 1'b0, 2};
      tv[3]  = '{1'b1, 4'b0010, 4'b0010, 1'b0, 3};
      tv[4]  = '{1'b1, 4'b0010, 4'b0010, 1'b0, 4};
      tv[5]  = '{1'b1, 4'b0010, 4'b0010, 1'b0, 5};
      tv[6]  = '{1'b0, 4'b0010, 4'b0010, 1'b0, 5};
      tv[7]  = '{1'b0, 4'b0110, 4'b0010, 1'b0, 5};
      tv[8]  = '{1'b1, 4'b0000, 4'b0010, 1'b0, 5};
      tv[9]  = '{1'b1, 4'b1000, 4'b0010, 1'b0, 5};
      tv[10] = '{1'b1, 4'b1111, 4'b0010, 1'b1, 5};

      do_reset();
      chk("rst_busy", {28'd0, busy0}, 0);
      chk("rst_pass", {28'd0, pass0 | pass1}, 0);
      chk("rst_fail", {28'd0, fail0 | fail1}, 0);
      chk("rst_cov", {16'd0, cov0}, 0);
      chk("rst_fcnt", {16'd0, fcnt0}, 0);
      chk("rst_oh", {31'd0, oh0}, 0);

      // one-hot-0 and cover table
      for (int i = 0; i < 11; i++) begin
         en        = tv[i].en;
         sig_in    = tv[i].sig;
         match_val = tv[i].mv;
         step();
         chk($sformatf("tv%0d_oh", i), {31'd0, oh0}, {31'd0, tv[i].exp_oh});
         chk($sformatf("tv%0d_cov", i), {16'd0, cov0}, tv[i].exp_cov);
      end
      chk("cov_sat", {30'd0, cov2}, 3);

      // T1 exact-mode pass
      do_reset();
      trig_a = 4'b0001; step(); trig_a = '0;
      chk("t1_busy", {28'd0, busy0}, 4'b0001);
      cyc(9);
      resp_b = 4'b0001; step(); resp_b = '0;
      chk("t1_pass", {28'd0, pass0}, 4'b0001);
      chk("t1_fail", {28'd0, fail0}, 0);
      chk("t1_busy_end", {28'd0, busy0}, 0);

      // T2 early response ignored in exact mode, passes window mode
      do_reset();
      trig_a = 4'b0010; step(); trig_a = '0;
      cyc(8);
      resp_b = 4'b0010; step(); resp_b = '0;
      chk("t2_pass0", {28'd0, pass0 | fail0}, 0);
      chk("t2_busy0", {28'd0, busy0}, 4'b0010);
      chk("t2_pass1", {28'd0, pass1}, 4'b0010);
      step();
      chk("t2_fail0", {28'd0, fail0}, 4'b0010);
      chk("t2_fcnt", {16'd0, fcnt0}, 1);

      // T3 window mode early pass
      do_reset();
      trig_a = 4'b0100; step(); trig_a = '0;
      cyc(2);
      resp_b = 4'b0100; step(); resp_b = '0;
      chk("t3_pass1", {28'd0, pass1}, 4'b0100);
      chk("t3_busy1", {28'd0, busy1}, 0);
      chk("t3_fail1", {28'd0, fail1}, 0);
      cyc(7);
      chk("t3_fail0", {28'd0, fail0}, 4'b0100);

      // T4 retrigger on the deciding edge
      do_reset();
      trig_a = 4'b1000; step(); trig_a = '0;
      cyc(9);
      trig_a = 4'b1000; step(); trig_a = '0;
      chk("t4_fail_a", {28'd0, fail0}, 4'b1000);
      chk("t4_busy_a", {28'd0, busy0}, 4'b1000);
      cyc(9);
      chk("t4_quiet", {28'd0, fail0}, 0);
      chk("t4_busy_b", {28'd0, busy0}, 4'b1000);
      step();
      chk("t4_fail_b", {28'd0, fail0}, 4'b1000);
      chk("t4_busy_c", {28'd0, busy0}, 0);
      chk("t4_fcnt", {16'd0, fcnt0}, 2);

      // T6 all channels fail together, narrow counter saturates
      do_reset();
      trig_a = 4'b1111; step(); trig_a = '0;
      cyc(10);
      chk("t6_fail4", {28'd0, fail0}, 4'b1111);
      chk("t6_fcnt4", {16'd0, fcnt0}, 4);
      chk("t6_sat", {30'd0, fcnt2}, 3);
      trig_a = 4'b0001; step(); trig_a = '0;
      cyc(10);
      chk("t6_fcnt5", {16'd0, fcnt0}, 5);
      chk("t6_sat2", {30'd0, fcnt2}, 3);

      // mid-window reset discards windows and counters
      trig_a = 4'b1111; step(); trig_a = '0;
      sig_in = 4'b0010;
      cyc(4);
      rst = 1'b1; step(); rst = 1'b0;
      sig_in = '0;
      chk("mr_busy", {28'd0, busy0}, 0);
      chk("mr_fcnt", {16'd0, fcnt0}, 0);
      chk("mr_cov", {16'd0, cov0}, 0);
      acc = '0;
      for (int k = 0; k < 12; k++) begin
         step();
         acc = acc | fail0 | pass0;
      end
      chk("mr_nopulse", {28'd0, acc}, 0);

      // en=0 aborts a window without a fail
      trig_a = 4'b0001; step(); trig_a = '0;
      cyc(2);
      en = 1'b0; step(); en = 1'b1;
      chk("en_busy", {28'd0, busy0}, 0);
      acc = '0;
      for (int k = 0; k < 12; k++) begin
         step();
         acc = acc | fail0;
      end
      chk("en_nofail", {28'd0, acc}, 0);
      chk("en_fcnt", {16'd0, fcnt0}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
